ps2_matrix_map: RTL



---
 rtl/ps2_matrix_map.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_matrix_map.sv
// ---------------------------------------------------------------------------
// ps2_matrix_map
//
// Purpose:
//   PS/2 keyboard front end for an emulated machine's key matrix. The block
//   filters the PS/2 clock line and deframes 11-bit frames. Each frame has a
//   start bit, 8 data bits sent LSB first, an odd parity bit and a stop bit.
//   A partial frame is dropped after TIMEOUT ce ticks with no clock edge.
//   The block follows E0/F0/E1 prefixes and looks up each plain code in a
//   host-loadable map RAM. The result is an active-low ROWS x COLS key
//   matrix plus NSPEC active-low special-key lines.
//
// Ports:
//   clock     in   1        system clock
//   reset     in   1        synchronous active-high reset
//   ce        in   1        clock enable; state advances only when ce=1
//                           (map RAM writes excepted)
//   ps2       in   2        bit1 = PS/2 data, bit0 = PS/2 clock (synchronised)
//   map_we    in   1        map RAM write strobe (any clock edge)
//   map_addr  in   9        {extended page, scancode}
//   map_data  in   2+RW+CW  entry {valid, special, row, col}
//   row       in   RW       matrix row select
//   dout      out  COLS     selected row, active-low. "do" is a reserved
//                           word in SystemVerilog, so this port is dout.
//   special   out  NSPEC    special keys, active-low
//
// Optional feature (macro PS2_RAW_EN):
//   raw_stb   out  1        one-ce strobe for every accepted code
//   raw_code  out  8        code that goes with raw_stb (prefixes included)
//   err       out  1        one-ce pulse on a parity error, a bad stop bit
//                           or a timeout
// ---------------------------------------------------------------------------
module ps2_matrix_map #(
    parameter int ROWS    = 10,
    parameter int COLS    = 8,
    parameter int NSPEC   = 4,
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 4000,
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int MW     = 2 + RW + CW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce,
    input  logic [1:0]       ps2,
    input  logic             map_we,
    input  logic [8:0]       map_addr,
    input  logic [MW-1:0]    map_data,
    input  logic [RW-1:0]    row,
    output logic [COLS-1:0]  dout,
    output logic [NSPEC-1:0] special
`ifdef PS2_RAW_EN
    ,
    output logic             raw_stb,
    output logic [7:0]       raw_code,
    output logic             err
`endif
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Clock filter and data register
    // ------------------------------------------------------------------
    logic [FILTER-1:0] shr_r;
    logic              level_r;
    logic              data_r;
    logic              fall_s;

    // The filtered clock falls only once per low phase, because level_r
    // drops on the same ce. The strobe is therefore exactly one ce wide.
    assign fall_s = level_r && (shr_r == {FILTER{1'b0}});

    // Sample history of the PS/2 clock, the filtered level and registered data
    always_ff @(posedge clock) begin
        if (reset) begin
            shr_r   <= {FILTER{1'b1}};
            level_r <= 1'b1;
            data_r  <= 1'b1;
        end else if (ce) begin
            shr_r  <= {shr_r[FILTER-2:0], ps2[0]};
            data_r <= ps2[1];
            if (shr_r == {FILTER{1'b1}}) begin
                level_r <= 1'b1;
            end else if (fall_s) begin
                level_r <= 1'b0;
            end else begin
                level_r <= level_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // Deframer with timeout
    // ------------------------------------------------------------------
    logic [3:0]    cnt_r;
    logic [7:0]    sh_r;
    logic          par_r;
    logic [TW-1:0] tmo_r;
    logic          rx_stb_r;
    logic [7:0]    rx_code_r;
    logic          frame_ok_s;
    logic          tmo_hit_s;

    // Odd parity across the data bits and the parity bit, and stop bit high
    assign frame_ok_s = data_r && (^{sh_r, par_r});
    assign tmo_hit_s  = (cnt_r != 4'd0) && !fall_s && (tmo_r == TMO_LAST);

    // Bit counter, shift register, timeout counter and rx strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r     <= 4'd0;
            sh_r      <= 8'h00;
            par_r     <= 1'b0;
            tmo_r     <= {TW{1'b0}};
            rx_stb_r  <= 1'b0;
            rx_code_r <= 8'h00;
        end else if (ce) begin
            rx_stb_r <= 1'b0;
            if (fall_s) begin
                tmo_r <= {TW{1'b0}};
                case (cnt_r)
                    4'd0: begin
                        if (!data_r) begin
                            cnt_r <= 4'd1;
                        end
                    end
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                        sh_r  <= {data_r, sh_r[7:1]};
                        cnt_r <= cnt_r + 4'd1;
                    end
                    4'd9: begin
                        par_r <= data_r;
                        cnt_r <= 4'd10;
                    end
                    4'd10: begin
                        cnt_r <= 4'd0;
                        if (frame_ok_s) begin
                            rx_stb_r  <= 1'b1;
                            rx_code_r <= sh_r;
                        end
                    end
                    default: begin
                        cnt_r <= 4'd0;
                    end
                endcase
            end else if (tmo_hit_s) begin
                cnt_r <= 4'd0;
                tmo_r <= {TW{1'b0}};
            end else if (cnt_r != 4'd0) begin
                tmo_r <= tmo_r + TW'(1);
            end else begin
                tmo_r <= {TW{1'b0}};
            end
        end
    end

`ifdef PS2_RAW_EN
    logic err_r;

    // Error pulse for a rejected frame or a timed-out partial frame
    always_ff @(posedge clock) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (ce) begin
            err_r <= (fall_s && (cnt_r == 4'd10) && !frame_ok_s) || tmo_hit_s;
        end
    end

    assign raw_stb  = rx_stb_r;
    assign raw_code = rx_code_r;
    assign err      = err_r;
`endif

    // ------------------------------------------------------------------
    // Map RAM
    // ------------------------------------------------------------------
    logic [MW-1:0] map_mem [512];

    // Host writes to the map ignore ce. The map is not reset.
    always_ff @(posedge clock) begin
        if (map_we) begin
            map_mem[map_addr] <= map_data;
        end
    end

    // ------------------------------------------------------------------
    // Prefix machine and key matrix
    // ------------------------------------------------------------------
    logic [2:0]       skip_r;
    logic             ext_r;
    logic             brk_r;
    logic             look_r;
    logic             lbrk_r;
    logic [MW-1:0]    entry_r;
    logic [COLS-1:0]  key_r [ROWS];
    logic [NSPEC-1:0] spec_r;

    logic             ent_valid_s;
    logic             ent_spec_s;
    logic [RW-1:0]    ent_row_s;
    logic [CW-1:0]    ent_col_s;

    assign ent_valid_s = entry_r[MW-1];
    assign ent_spec_s  = entry_r[MW-2];
    assign ent_row_s   = entry_r[CW+RW-1:CW];
    assign ent_col_s   = entry_r[CW-1:0];

    // The map entry is read on the ce that carries rx. It is applied on the
    // following ce, with the break flag captured at the same time as the read.
    always_ff @(posedge clock) begin
        if (reset) begin
            skip_r  <= 3'd0;
            ext_r   <= 1'b0;
            brk_r   <= 1'b0;
            look_r  <= 1'b0;
            lbrk_r  <= 1'b1;
            entry_r <= {MW{1'b0}};
            spec_r  <= {NSPEC{1'b1}};
            for (int r = 0; r < ROWS; r++) begin
                key_r[r] <= {COLS{1'b1}};
            end
        end else if (ce) begin
            look_r <= 1'b0;

            // Apply a pending lookup. Targets outside the matrix or beyond
            // the special bank match no loop index and have no effect.
            if (look_r && ent_valid_s) begin
                if (ent_spec_s) begin
                    for (int c = 0; c < NSPEC; c++) begin
                        if (ent_col_s == CW'(c)) begin
                            spec_r[c] <= lbrk_r;
                        end
                    end
                end else begin
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS; c++) begin
                            if ((ent_row_s == RW'(r)) && (ent_col_s == CW'(c))) begin
                                key_r[r][c] <= lbrk_r;
                            end
                        end
                    end
                end
            end

            if (rx_stb_r) begin
                if (skip_r != 3'd0) begin
                    skip_r <= skip_r - 3'd1;
                end else begin
                    case (rx_code_r)
                        8'hE1: skip_r <= 3'd7;  // Pause: swallow the rest
                        8'hE0: ext_r  <= 1'b1;
                        8'hF0: brk_r  <= 1'b1;
                        8'hAA: begin
                            // Keyboard self-test / hot-plug: release everything
                            ext_r  <= 1'b0;
                            brk_r  <= 1'b0;
                            spec_r <= {NSPEC{1'b1}};
                            for (int r = 0; r < ROWS; r++) begin
                                key_r[r] <= {COLS{1'b1}};
                            end
                        end
                        default: begin
                            entry_r <= map_mem[{ext_r, rx_code_r}];
                            look_r  <= 1'b1;
                            lbrk_r  <= brk_r;
                            ext_r   <= 1'b0;
                            brk_r   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dout    = (int'(row) < ROWS) ? key_r[row] : {COLS{1'b1}};
    assign special = spec_r;

endmodule
